// File: rtl/fp_pkg.sv
// Shared fp32 types, constants and classification helpers for the
// fp_mult issue stage and its benches.
package fp_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] man;
  } fp32_t;

  localparam logic [7:0]  FP_EXP_MAX = 8'hFF;
  localparam int unsigned FP_BIAS    = 127;
  localparam logic [31:0] FP_QNAN    = 32'h7FC0_0000;

  function automatic logic is_nan(input fp32_t x);
    return (x.exp == FP_EXP_MAX) && (x.man != '0);
  endfunction

  function automatic logic is_inf(input fp32_t x);
    return (x.exp == FP_EXP_MAX) && (x.man == '0);
  endfunction

  function automatic logic is_zero(input fp32_t x);
    return (x.exp == '0) && (x.man == '0);
  endfunction

endpackage

// File: rtl/fp_sync_fifo.sv
// Synchronous FIFO with registered storage. Pointers carry one extra MSB
// so full and empty are distinguished without a separate flag.
module fp_sync_fifo #(
  parameter int unsigned W     = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic [W-1:0] mem_q [DEPTH];

  // Pointer advance on push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write; contents need no reset since reads are qualified by empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q[AW-1:0]];
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/fp_mult_issue.sv
// Issue stage for the fixed-latency fp_mult: buffers operand pairs, issues
// at most one per clock when the result FIFO has a guaranteed slot, tracks
// in-flight products with a valid/tag shift register and returns results in
// issue order.
module fp_mult_issue
  import fp_pkg::*;
#(
  parameter int unsigned MULT_LAT  = 3,
  parameter int unsigned IN_DEPTH  = 4,
  parameter int unsigned OUT_DEPTH = 4,
  parameter int unsigned TAG_W     = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic [31:0]      mult_a,
  output logic [31:0]      mult_b,
  input  logic [31:0]      mult_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int unsigned IN_W   = 64 + TAG_W;
  localparam int unsigned OUT_W  = 32 + TAG_W;
  localparam int unsigned IN_CW  = $clog2(IN_DEPTH) + 1;
  localparam int unsigned OUT_CW = $clog2(OUT_DEPTH) + 1;
  localparam int unsigned FL_W   = $clog2(MULT_LAT + 1);
  localparam logic [FL_W-1:0] FL_ONE = {{(FL_W-1){1'b0}}, 1'b1};

  logic                rdy_q, rdy_d;
  fp32_t               mult_a_q, mult_a_d;
  fp32_t               mult_b_q, mult_b_d;
  logic [MULT_LAT-1:0] vld_sr_q, vld_sr_d;
  logic [TAG_W-1:0]    tag_sr_q [MULT_LAT];
  logic [TAG_W-1:0]    tag_sr_d [MULT_LAT];
  logic [FL_W-1:0]     inflight_q, inflight_d;

  logic              in_push, in_full, in_empty;
  logic [IN_CW-1:0]  in_count;
  logic [IN_W-1:0]   in_rdata;
  logic              cap, out_pop, out_full, out_empty;
  logic [OUT_CW-1:0] out_count;
  logic [OUT_W-1:0]  out_rdata;
  logic              issue;

  // in_ready stays low until the first edge after reset release.
  assign in_ready = rdy_q & ~in_full;
  assign in_push  = in_valid & in_ready;

  fp_sync_fifo #(.W(IN_W), .DEPTH(IN_DEPTH)) u_in_fifo (
    .clk   (clock),
    .rst_n (reset_n),
    .push  (in_push),
    .wdata ({in_a, in_b, in_tag}),
    .pop   (issue),
    .rdata (in_rdata),
    .full  (in_full),
    .empty (in_empty),
    .count (in_count)
  );

  // Credits come from registered counts only, so a same-cycle pop frees its
  // slot one cycle later; every issued product is guaranteed a result slot.
  assign issue = ~in_empty &&
                 ((32'(inflight_q) + 32'(out_count)) < OUT_DEPTH);
  assign cap   = vld_sr_q[MULT_LAT-1];

  fp_sync_fifo #(.W(OUT_W), .DEPTH(OUT_DEPTH)) u_out_fifo (
    .clk   (clock),
    .rst_n (reset_n),
    .push  (cap),
    .wdata ({mult_result, tag_sr_q[MULT_LAT-1]}),
    .pop   (out_pop),
    .rdata (out_rdata),
    .full  (out_full),
    .empty (out_empty),
    .count (out_count)
  );

  // A capture into a full result FIFO would mean the credit check is broken.
  always_comb begin
    if (reset_n) assert (!(cap && out_full));
  end

  assign out_valid  = ~out_empty;
  assign out_pop    = out_valid & out_ready;
  assign out_result = out_empty ? '0 : out_rdata[OUT_W-1:TAG_W];
  assign out_tag    = out_empty ? '0 : out_rdata[TAG_W-1:0];
  assign mult_a     = mult_a_q;
  assign mult_b     = mult_b_q;
  assign busy       = (in_count != '0) || (inflight_q != '0) || ~out_empty;

  // Operand register load, valid/tag shift and in-flight count.
  always_comb begin
    rdy_d       = 1'b1;
    mult_a_d    = mult_a_q;
    mult_b_d    = mult_b_q;
    vld_sr_d    = '0;
    tag_sr_d[0] = in_rdata[TAG_W-1:0];
    inflight_d  = inflight_q;
    if (issue) begin
      mult_a_d = fp32_t'(in_rdata[IN_W-1 -: 32]);
      mult_b_d = fp32_t'(in_rdata[TAG_W+31:TAG_W]);
    end
    vld_sr_d[0] = issue;
    for (int unsigned i = 1; i < MULT_LAT; i++) begin
      vld_sr_d[i] = vld_sr_q[i-1];
      tag_sr_d[i] = tag_sr_q[i-1];
    end
    if (issue && !cap)      inflight_d = inflight_q + FL_ONE;
    else if (!issue && cap) inflight_d = inflight_q - FL_ONE;
  end

  // State registers; reset drops everything queued or in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rdy_q      <= 1'b0;
      mult_a_q   <= '0;
      mult_b_q   <= '0;
      vld_sr_q   <= '0;
      tag_sr_q   <= '{default: '0};
      inflight_q <= '0;
    end else begin
      rdy_q      <= rdy_d;
      mult_a_q   <= mult_a_d;
      mult_b_q   <= mult_b_d;
      vld_sr_q   <= vld_sr_d;
      tag_sr_q   <= tag_sr_d;
      inflight_q <= inflight_d;
    end
  end

endmodule

// File: tb/tb_fp_mult_issue.sv
// Directed bench for fp_mult_issue with a behavioural fp_mult (MULT_LAT=3)
// and an in-order result/tag scoreboard.
module tb_fp_mult_issue;
  import fp_pkg::*;

  localparam int unsigned MULT_LAT  = 3;
  localparam int unsigned IN_DEPTH  = 4;
  localparam int unsigned OUT_DEPTH = 4;
  localparam int unsigned TAG_W     = 4;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_a = '0;
  logic [31:0]      in_b = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic [31:0]      mult_a, mult_b, mult_result;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_result;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  typedef struct {
    logic [31:0]      r;
    logic [TAG_W-1:0] t;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned rcv = 0;
  bit          toggle_ready = 1'b0;

  // 1.0 .. 16.0
  logic [31:0] nums [16] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                             32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000,
                             32'h41100000, 32'h41200000, 32'h41300000, 32'h41400000,
                             32'h41500000, 32'h41600000, 32'h41700000, 32'h41800000};
  // 2.0 * nums
  logic [31:0] dbl  [16] = '{32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000,
                             32'h41200000, 32'h41400000, 32'h41600000, 32'h41800000,
                             32'h41900000, 32'h41A00000, 32'h41B00000, 32'h41C00000,
                             32'h41D00000, 32'h41E00000, 32'h41F00000, 32'h42000000};
  // 3.0 * nums[0..9]
  logic [31:0] trip [10] = '{32'h40400000, 32'h40C00000, 32'h41100000, 32'h41400000,
                             32'h41700000, 32'h41900000, 32'h41A80000, 32'h41C00000,
                             32'h41D80000, 32'h41F00000};

  fp_mult_issue #(
    .MULT_LAT  (MULT_LAT),
    .IN_DEPTH  (IN_DEPTH),
    .OUT_DEPTH (OUT_DEPTH),
    .TAG_W     (TAG_W)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_tag      (in_tag),
    .mult_a      (mult_a),
    .mult_b      (mult_b),
    .mult_result (mult_result),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_tag     (out_tag),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  // Behavioural single-precision multiply: exact for normal operands whose
  // product needs no rounding; denormals flush to zero.
  function automatic logic [31:0] fmul(input fp32_t a, input fp32_t b);
    logic        s;
    logic [47:0] p;
    logic [22:0] m;
    int          e;
    s = a.sign ^ b.sign;
    if (is_nan(a) || is_nan(b)) return FP_QNAN;
    if ((is_inf(a) && b.exp == '0) || (is_inf(b) && a.exp == '0)) return FP_QNAN;
    if (is_inf(a) || is_inf(b)) return {s, FP_EXP_MAX, 23'd0};
    if (a.exp == '0 || b.exp == '0) return {s, 31'd0};
    p = {24'd0, 1'b1, a.man} * {24'd0, 1'b1, b.man};
    e = int'(a.exp) + int'(b.exp) - int'(FP_BIAS);
    if (p[47]) begin
      m = p[46:24];
      e = e + 1;
    end else begin
      m = p[45:23];
    end
    if (e >= 255) return {s, FP_EXP_MAX, 23'd0};
    if (e <= 0) return {s, 31'd0};
    return {s, e[7:0], m};
  endfunction

  // fp_mult stand-in: mult_a update edge to result sample edge is MULT_LAT.
  logic [31:0] pipe_q [MULT_LAT-1];
  always @(posedge clock) begin
    pipe_q[0] <= fmul(mult_a, mult_b);
    for (int i = 1; i < int'(MULT_LAT) - 1; i++) pipe_q[i] <= pipe_q[i-1];
  end
  assign mult_result = pipe_q[MULT_LAT-2];

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic sync();
    @(posedge clock);
    #1;
  endtask

  // Offer a pair for up to budget cycles; leaves in_valid asserted.
  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] t,
                      input logic [31:0] r, input int unsigned budget, output bit acc);
    in_a = a;
    in_b = b;
    in_tag = t;
    in_valid = 1'b1;
    acc = 1'b0;
    for (int unsigned n = 0; n < budget && !acc; n++) begin
      @(negedge clock);
      acc = in_ready;
      @(posedge clock);
      #1;
      if (toggle_ready) out_ready = ~out_ready;
    end
    if (acc) exp_q.push_back('{r, t});
  endtask

  task automatic wait_rcv(input string name, input int unsigned target, input int unsigned budget);
    for (int unsigned n = 0; n < budget && rcv < target; n++) sync();
    check(name, 64'(rcv), 64'(target));
  endtask

  // Scoreboard and credit invariant, sampled away from the active edge.
  always @(negedge clock) begin
    if (reset_n) begin
      check("credit_bound", 64'((32'(dut.out_count) + 32'(dut.inflight_q)) <= OUT_DEPTH), 64'(1));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 64'(out_valid), 64'(0));
        end else begin
          check("sb_result", 64'(out_result), 64'(exp_q[0].r));
          check("sb_tag", 64'(out_tag), 64'(exp_q[0].t));
          void'(exp_q.pop_front());
          rcv++;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          acc;
    int unsigned base;
    int unsigned stale;

    // Reset state
    repeat (2) @(negedge clock);
    check("rst_in_ready", 64'(in_ready), 64'(0));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_mult_a", 64'(mult_a), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_out_result", 64'(out_result), 64'(0));
    sync();
    reset_n = 1'b1;
    @(negedge clock);
    check("in_ready_before_edge", 64'(in_ready), 64'(0));
    @(negedge clock);
    check("in_ready_after_edge", 64'(in_ready), 64'(1));

    // 1. Single op: 1.0 * 2.0, tag 5
    out_ready = 1'b1;
    sync();
    push(32'h3F800000, 32'h40000000, 4'd5, 32'h40000000, 1, acc);
    in_valid = 1'b0;
    check("t1_accept", 64'(acc), 64'(1));
    for (int i = 1; i <= 5; i++) begin
      @(negedge clock);
      check("t1_latency", 64'(out_valid), 64'(i == 5));
      if (i == 2) begin
        check("t1_mult_a", 64'(mult_a), 64'h3F800000);
        check("t1_mult_b", 64'(mult_b), 64'h40000000);
      end
      if (i == 5) begin
        check("t1_out_result", 64'(out_result), 64'h40000000);
        check("t1_out_tag", 64'(out_tag), 64'(5));
      end
    end
    @(negedge clock);
    check("t1_busy_after_pop", 64'(busy), 64'(0));
    check("t1_valid_after_pop", 64'(out_valid), 64'(0));

    // 2. Streaming 16 pairs. A credit returns one cycle after its pop, so a
    // credit round trip is MULT_LAT+2 clocks: the last product is captured
    // 7 edges after the last push and popped on the 8th.
    sync();
    base = rcv;
    for (int i = 0; i < 16; i++) begin
      push(32'h40000000, nums[i], 4'(i), dbl[i], 1, acc);
      check("t2_in_ready", 64'(acc), 64'(1));
    end
    in_valid = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clock);
      if (k == 8) check("t2_last_valid", 64'(out_valid), 64'(1));
      if (k == 9) begin
        check("t2_drained_valid", 64'(out_valid), 64'(0));
        check("t2_count", 64'(rcv), 64'(base + 16));
      end
    end

    // 3. Backpressure: 4 issue on credits, 4 more fill the operand FIFO
    out_ready = 1'b0;
    sync();
    base = rcv;
    for (int i = 0; i < 8; i++) begin
      push(32'h40400000, nums[i], 4'(i + 6), trip[i], 1, acc);
      check("t3_accept", 64'(acc), 64'(1));
    end
    in_valid = 1'b0;
    repeat (4) @(negedge clock);
    check("t3_in_ready_low", 64'(in_ready), 64'(0));
    check("t3_out_valid", 64'(out_valid), 64'(1));
    check("t3_head_result", 64'(out_result), 64'(trip[0]));
    check("t3_head_tag", 64'(out_tag), 64'(6));
    check("t3_out_count", 64'(dut.out_count), 64'(OUT_DEPTH));
    check("t3_busy", 64'(busy), 64'(1));
    sync();
    push(32'h40400000, nums[8], 4'd14, trip[8], 3, acc);
    check("t3_blocked", 64'(acc), 64'(0));
    out_ready = 1'b1;
    push(32'h40400000, nums[8], 4'd14, trip[8], 20, acc);
    check("t3_accept9", 64'(acc), 64'(1));
    push(32'h40400000, nums[9], 4'd15, trip[9], 20, acc);
    check("t3_accept10", 64'(acc), 64'(1));
    in_valid = 1'b0;
    wait_rcv("t3_drain", base + 10, 60);

    // 4. Special operands pass through fp_mult untouched
    sync();
    base = rcv;
    push(32'h7F800000, 32'h00000000, 4'd9,  32'h7FC00000, 1, acc);
    check("t4_accept", 64'(acc), 64'(1));
    push(32'h7FC00000, 32'h3F800000, 4'd10, 32'h7FC00000, 1, acc);
    check("t4_accept", 64'(acc), 64'(1));
    push(32'hFF800000, 32'h40000000, 4'd11, 32'hFF800000, 1, acc);
    check("t4_accept", 64'(acc), 64'(1));
    push(32'h80000000, 32'h3F800000, 4'd12, 32'h80000000, 1, acc);
    check("t4_accept", 64'(acc), 64'(1));
    in_valid = 1'b0;
    wait_rcv("t4_drain", base + 4, 40);

    // 5. Reset with results buffered, ops in flight and pairs queued
    out_ready = 1'b0;
    sync();
    push(32'h40000000, nums[0], 4'd1, dbl[0], 1, acc);
    push(32'h40000000, nums[1], 4'd2, dbl[1], 1, acc);
    in_valid = 1'b0;
    repeat (8) sync();
    for (int i = 2; i < 7; i++) begin
      push(32'h40000000, nums[i], 4'(i + 1), dbl[i], 1, acc);
      check("t5_accept", 64'(acc), 64'(1));
    end
    in_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    check("t5_rst_in_ready", 64'(in_ready), 64'(0));
    check("t5_rst_out_valid", 64'(out_valid), 64'(0));
    check("t5_rst_out_result", 64'(out_result), 64'(0));
    check("t5_rst_out_tag", 64'(out_tag), 64'(0));
    check("t5_rst_mult_a", 64'(mult_a), 64'(0));
    check("t5_rst_mult_b", 64'(mult_b), 64'(0));
    check("t5_rst_busy", 64'(busy), 64'(0));
    exp_q.delete();
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    out_ready = 1'b1;
    stale = 0;
    repeat (10) begin
      @(negedge clock);
      if (out_valid) stale++;
    end
    check("t5_no_stale", 64'(stale), 64'(0));
    sync();
    base = rcv;
    push(32'h40400000, 32'h40400000, 4'd3, 32'h41100000, 2, acc);
    in_valid = 1'b0;
    check("t5_new_accept", 64'(acc), 64'(1));
    wait_rcv("t5_new_result", base + 1, 20);

    // 6. Toggling out_ready mixes capture+pop and issue+capture edges
    toggle_ready = 1'b1;
    sync();
    base = rcv;
    for (int i = 0; i < 12; i++) begin
      push(32'h3F800000, nums[i], 4'(i), nums[i], 20, acc);
      check("t6_accept", 64'(acc), 64'(1));
    end
    in_valid = 1'b0;
    toggle_ready = 1'b0;
    out_ready = 1'b1;
    wait_rcv("t6_drain", base + 12, 80);

    repeat (2) @(negedge clock);
    check("sb_empty", 64'(exp_q.size()), 64'(0));
    check("final_busy", 64'(busy), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
